if_prefetch: RTL



---
 rtl/if_prefetch_pkg.sv | 20 ++
 rtl/if_prefetch_if.sv | 23 ++
 rtl/if_prefetch_fifo.sv | 58 +++++
 rtl/if_prefetch.sv | 112 +++++++++++
 4 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared fetch-path types and constants: queue entry layout, halt opcode, fetch FSM states.
package risc_pkg;

    localparam int XLEN = 32;
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] npc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fsm_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side valid/ready head.
interface if_prefetch_if #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 10
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [XLEN-1:0]    imem_rdata;
    logic               id_valid;
    logic               id_ready;
    logic [XLEN-1:0]    id_ir;
    logic [XLEN-1:0]    id_npc;

    modport master (
        output imem_req, imem_addr, id_valid, id_ir, id_npc,
        input  imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_ir, id_npc,
        output imem_rdata, id_ready
    );
endinterface

// File: rtl/if_prefetch_fifo.sv
// Circular prefetch queue of {ir, npc} entries with push/pop/flush and an occupancy count.
module if_prefetch_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  risc_pkg::fetch_entry_t wdata,
    input  logic                   pop,
    input  logic                   flush,
    output risc_pkg::fetch_entry_t head,
    output logic [AW:0]            count
);
    import risc_pkg::*;

    localparam logic [AW:0] ONE = 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: ;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // Slots are reserved at issue time, so a push into a full queue means the accounting broke.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && count == FULL));

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: sequential imem prefetch into a small queue, redirect flush, decode handshake.
// Optional IF_HALT_STOP_EN: a captured halt opcode stops fetch until the next redirect.
module if_prefetch #(
    parameter int XLEN    = risc_pkg::XLEN,
    parameter int IMEM_AW = 10,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    if_prefetch_if.master      bus,
    input  logic               redir_valid,
    input  logic [IMEM_AW-1:0] redir_pc,
    input  logic               hlt
);
    import risc_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fsm_t               state;
    fsm_t               state_nxt;
    logic [IMEM_AW-1:0] pc;
    logic [IMEM_AW-1:0] infl_addr;
    logic [IMEM_AW-1:0] infl_next;
    logic               inflight;
    logic               issue;
    logic               capture;
    logic               pop;
    logic               halt_hit;
    logic [CW-1:0]      count;
    logic [CW:0]        occupancy;
    fetch_entry_t       enq;
    fetch_entry_t       head;

    // A response returning in a redirect cycle is dropped here; the fifo flush drops everything queued.
    assign capture   = inflight && !redir_valid;
    assign infl_next = infl_addr + IMEM_AW'(1);
    assign occupancy = {1'b0, count} + (CW+1)'(inflight);

    always_comb begin
        enq.ir  = bus.imem_rdata;
        enq.npc = XLEN'(infl_next);
    end

`ifdef IF_HALT_STOP_EN
    assign halt_hit = capture && (state == RUN) && (enq.ir[OPC_HI:OPC_LO] == OPC_HALT);
`else
    assign halt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (halt_hit) state_nxt = HALTED;
            HALTED:  if (redir_valid) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue         = (state == RUN) && !hlt && !redir_valid
                        && (occupancy < (CW+1)'(DEPTH));
        pop           = bus.id_valid && bus.id_ready;
        bus.imem_req  = issue;
        bus.imem_addr = pc;
        bus.id_valid  = (count != '0);
        bus.id_ir     = head.ir;
        bus.id_npc    = head.npc;
    end

    // pc is the next address to request, so a redirect loads the target itself and the issue bumps it.
    // The request issued alongside a captured halt word is killed: it lies past the halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            inflight  <= 1'b0;
            infl_addr <= '0;
        end else begin
            if (redir_valid) begin
                pc <= redir_pc;
            end else if (issue) begin
                pc <= pc + IMEM_AW'(1);
            end
            inflight <= issue && !halt_hit;
            if (issue) begin
                infl_addr <= pc;
            end
        end
    end

    if_prefetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (capture),
        .wdata (enq),
        .pop   (pop),
        .flush (redir_valid),
        .head  (head),
        .count (count)
    );

endmodule
